// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master controller: FSM states, op types and
// the quarter-phase encoding used by the bit timing.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_DEV_W,
        ST_ADDR,
        ST_WR_DATA,
        ST_RESTART,
        ST_DEV_R,
        ST_RD_DATA,
        ST_STOP
    } state_t;

    localparam logic P_OP_WRITE = 1'b0;
    localparam logic P_OP_READ  = 1'b1;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period tick generator: a clock divider plus a 2-bit phase counter
// that advances Q0..Q3 on every tick.
module i2c_tick_gen
    import i2c_pkg::*;
#(
    parameter int P_CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic       tick,
    output logic [1:0] phase
);

    localparam int CW = (P_CLK_DIV > 1) ? $clog2(P_CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(P_CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt   <= '0;
            phase <= Q0;
        end else if (en) begin
            if (tick) begin
                cnt   <= '0;
                phase <= phase + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// I2C master for EEPROM-class devices: page writes and sequential random reads
// with slave-ACK checking, master ACK/NACK and open-drain SDA.
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int P_ADDR_BYTES = 2,
    parameter int P_CLK_DIV    = 125,
    parameter int P_LEN_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                i_slave_addr,
    input  logic [8*P_ADDR_BYTES-1:0] i_op_addr,
    input  logic [P_LEN_WIDTH-1:0]    i_op_len,
    input  logic                      i_op_type,
    input  logic                      i_op_valid,
    output logic                      o_op_ready,
    input  logic [7:0]                i_wr_data,
    output logic                      o_wr_req,
    output logic [7:0]                o_rd_data,
    output logic                      o_rd_valid,
    output logic                      o_done,
    output logic                      o_nack,
    output logic                      o_i2c_scl,
    inout  wire                       io_i2c_sda
);

    state_t state, state_nxt;

    logic                      tick;
    logic [1:0]                phase;
    logic [6:0]                slave_r;
    logic [8*P_ADDR_BYTES-1:0] addr_sh;
    logic [P_LEN_WIDTH-1:0]    len_r, byte_cnt;
    logic                      type_r;
    logic [1:0]                addr_cnt;
    logic [3:0]                bit_cnt;
    logic [7:0]                shift_r, wr_buf;
    logic                      wr_pend, wr_req_d, ack_bit, nack_r;
    logic [1:0]                sda_sync;
    logic                      sda_in;
    logic                      scl_r, sda_oe_r, scl_c, sda_low_c;
    logic                      accept, bit_end, sample_pt, byte_st, tx_st, ack_end, last_addr, wr_issue;

    assign o_op_ready = (state == ST_IDLE) && !o_done;
    assign accept     = o_op_ready && i_op_valid;
    assign sda_in     = sda_sync[1];
    assign bit_end    = tick && (phase == Q3);
    assign sample_pt  = tick && (phase == Q1);
    assign tx_st      = (state == ST_DEV_W) || (state == ST_ADDR) ||
                        (state == ST_WR_DATA) || (state == ST_DEV_R);
    assign byte_st    = tx_st || (state == ST_RD_DATA);
    assign ack_end    = byte_st && bit_end && (bit_cnt == 4'd8);
    assign last_addr  = (state == ST_ADDR) && (addr_cnt == 2'd0);
    // Next write byte is requested as the ACK bit begins so it is ready before the slot ends
    assign wr_issue   = byte_st && bit_end && (bit_cnt == 4'd7) && (type_r == P_OP_WRITE) &&
                        (last_addr || (state == ST_WR_DATA)) && (byte_cnt < len_r);

    assign o_i2c_scl  = scl_r;
    assign io_i2c_sda = sda_oe_r ? 1'b0 : 1'bz;

    i2c_tick_gen #(
        .P_CLK_DIV(P_CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state != ST_IDLE),
        .clr  (accept),
        .tick (tick),
        .phase(phase)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        scl_c     = 1'b1;
        sda_low_c = 1'b0;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_START;
            ST_START: begin
                scl_c     = (phase != Q3);
                sda_low_c = (phase == Q2) || (phase == Q3);
                if (bit_end) state_nxt = ST_DEV_W;
            end
            ST_RESTART: begin
                scl_c     = (phase == Q1) || (phase == Q2);
                sda_low_c = (phase == Q2) || (phase == Q3);
                if (bit_end) state_nxt = ST_DEV_R;
            end
            ST_STOP: begin
                scl_c     = (phase != Q0);
                sda_low_c = (phase == Q0) || (phase == Q1);
                if (bit_end) state_nxt = ST_IDLE;
            end
            ST_DEV_W, ST_ADDR, ST_WR_DATA, ST_DEV_R: begin
                scl_c     = (phase == Q1) || (phase == Q2);
                sda_low_c = (bit_cnt != 4'd8) && !shift_r[7];
                if (ack_end) begin
                    if (ack_bit)                     state_nxt = ST_STOP;
                    else if (state == ST_DEV_W)      state_nxt = ST_ADDR;
                    else if (state == ST_DEV_R)      state_nxt = ST_RD_DATA;
                    else if (state == ST_WR_DATA)    state_nxt = wr_pend ? ST_WR_DATA : ST_STOP;
                    else if (addr_cnt != 2'd0)       state_nxt = ST_ADDR;
                    else if (type_r == P_OP_READ)    state_nxt = (len_r == '0) ? ST_STOP : ST_RESTART;
                    else                             state_nxt = wr_pend ? ST_WR_DATA : ST_STOP;
                end
            end
            ST_RD_DATA: begin
                scl_c     = (phase == Q1) || (phase == Q2);
                sda_low_c = (bit_cnt == 4'd8) && (byte_cnt != len_r);
                if (ack_end) state_nxt = (byte_cnt == len_r) ? ST_STOP : ST_RD_DATA;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slave_r    <= '0;
            addr_sh    <= '0;
            len_r      <= '0;
            type_r     <= P_OP_WRITE;
            byte_cnt   <= '0;
            addr_cnt   <= '0;
            bit_cnt    <= '0;
            shift_r    <= '0;
            wr_buf     <= '0;
            wr_pend    <= 1'b0;
            wr_req_d   <= 1'b0;
            ack_bit    <= 1'b0;
            nack_r     <= 1'b0;
            sda_sync   <= '1;
            scl_r      <= 1'b1;
            sda_oe_r   <= 1'b0;
            o_wr_req   <= 1'b0;
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
            o_done     <= 1'b0;
            o_nack     <= 1'b0;
        end else begin
            sda_sync   <= {sda_sync[0], io_i2c_sda};
            scl_r      <= scl_c;
            sda_oe_r   <= sda_low_c;
            o_wr_req   <= wr_issue;
            wr_req_d   <= o_wr_req;
            o_rd_valid <= 1'b0;
            o_done     <= 1'b0;
            o_nack     <= 1'b0;

            if (accept) begin
                slave_r  <= i_slave_addr;
                addr_sh  <= i_op_addr;
                len_r    <= i_op_len;
                type_r   <= i_op_type;
                byte_cnt <= '0;
                bit_cnt  <= '0;
                wr_pend  <= 1'b0;
                nack_r   <= 1'b0;
            end

            if (wr_req_d) wr_buf <= i_wr_data;
            if (wr_issue) begin
                byte_cnt <= byte_cnt + 1'b1;
                wr_pend  <= 1'b1;
            end

            if (byte_st && sample_pt) begin
                if (bit_cnt == 4'd8) begin
                    ack_bit <= sda_in;
                end else if (state == ST_RD_DATA) begin
                    shift_r <= {shift_r[6:0], sda_in};
                    if (bit_cnt == 4'd7) begin
                        o_rd_data  <= {shift_r[6:0], sda_in};
                        o_rd_valid <= 1'b1;
                        byte_cnt   <= byte_cnt + 1'b1;
                    end
                end
            end

            if (byte_st && bit_end) begin
                bit_cnt <= (bit_cnt == 4'd8) ? 4'd0 : bit_cnt + 4'd1;
                if (tx_st && (bit_cnt != 4'd8)) shift_r <= {shift_r[6:0], 1'b0};
            end

            if (bit_end && (state == ST_START))   shift_r <= {slave_r, 1'b0};
            if (bit_end && (state == ST_RESTART)) shift_r <= {slave_r, 1'b1};
            if (bit_end && (state == ST_STOP)) begin
                o_done <= 1'b1;
                o_nack <= nack_r;
            end

            if (ack_end) begin
                case (state_nxt)
                    ST_ADDR: begin
                        shift_r  <= addr_sh[8*P_ADDR_BYTES-1 -: 8];
                        addr_sh  <= addr_sh << 8;
                        addr_cnt <= (state == ST_DEV_W) ? 2'(P_ADDR_BYTES - 1) : addr_cnt - 2'd1;
                    end
                    ST_WR_DATA: begin
                        shift_r <= wr_buf;
                        wr_pend <= 1'b0;
                    end
                    ST_STOP: if (tx_st && ack_bit) nack_r <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl: a behavioural EEPROM-like slave on the
// bus logs every byte and START/STOP, and drives read data and ACKs.
module tb_i2c_master_ctrl;

    localparam int MK_START = 256;
    localparam int MK_STOP  = 257;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  slave_addr = 7'h50;
    logic [15:0] op_addr_a = '0;
    logic [7:0]  op_addr_b = '0;
    logic [7:0]  op_len = '0;
    logic        op_type = 1'b0;
    logic        valid_a = 1'b0, valid_b = 1'b0;
    logic [7:0]  wr_data = '0;

    logic        ready_a, wr_req_a, rd_valid_a, done_a, nack_a, scl_a;
    logic        ready_b, wr_req_b, rd_valid_b, done_b, nack_b, scl_b;
    logic [7:0]  rd_data_a, rd_data_b;
    wire         sda_a, sda_b;

    logic        sel_b = 1'b0;
    logic        slave_low = 1'b0;
    logic        present = 1'b1;

    pullup (sda_a);
    pullup (sda_b);
    assign sda_a = (!sel_b && slave_low) ? 1'b0 : 1'bz;
    assign sda_b = ( sel_b && slave_low) ? 1'b0 : 1'bz;

    wire bus_scl     = sel_b ? scl_b : scl_a;
    wire bus_sda     = sel_b ? sda_b : sda_a;
    wire wr_req_sel  = sel_b ? wr_req_b : wr_req_a;
    wire rd_valid_sel= sel_b ? rd_valid_b : rd_valid_a;
    wire [7:0] rd_data_sel = sel_b ? rd_data_b : rd_data_a;
    wire done_sel    = sel_b ? done_b : done_a;
    wire nack_sel    = sel_b ? nack_b : nack_a;

    i2c_master_ctrl #(.P_ADDR_BYTES(2), .P_CLK_DIV(4), .P_LEN_WIDTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_slave_addr(slave_addr), .i_op_addr(op_addr_a),
        .i_op_len(op_len), .i_op_type(op_type), .i_op_valid(valid_a), .o_op_ready(ready_a),
        .i_wr_data(wr_data), .o_wr_req(wr_req_a), .o_rd_data(rd_data_a), .o_rd_valid(rd_valid_a),
        .o_done(done_a), .o_nack(nack_a), .o_i2c_scl(scl_a), .io_i2c_sda(sda_a)
    );

    i2c_master_ctrl #(.P_ADDR_BYTES(1), .P_CLK_DIV(4), .P_LEN_WIDTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_slave_addr(slave_addr), .i_op_addr(op_addr_b),
        .i_op_len(op_len), .i_op_type(op_type), .i_op_valid(valid_b), .o_op_ready(ready_b),
        .i_wr_data(wr_data), .o_wr_req(wr_req_b), .o_rd_data(rd_data_b), .o_rd_valid(rd_valid_b),
        .o_done(done_b), .o_nack(nack_b), .o_i2c_scl(scl_b), .io_i2c_sda(sda_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave model state
    int         bus_log[$];
    int         exp_log[$];
    int         mack_log[$];
    logic [7:0] rd_vals[$];
    int         rd_idx = 0;
    int         bitn = 0;
    logic [7:0] rx = '0, tx = '0;
    logic       mode_read = 1'b0, pend_read = 1'b0, first_byte = 1'b0, mack = 1'b0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1;

    // Op-side monitor state
    logic [7:0] wr_vals[$];
    int         wr_idx = 0;
    int         wr_cnt = 0;
    logic [7:0] rd_log[$];
    int         done_cnt = 0;
    int         nack_stray = 0;
    logic       nack_at_done = 1'b0;

    always @(negedge clk) begin
        if (prev_scl && bus_scl && prev_sda && !bus_sda) begin
            bus_log.push_back(MK_START);
            bitn = 0; mode_read = 1'b0; pend_read = 1'b0; first_byte = 1'b1; slave_low = 1'b0;
        end else if (prev_scl && bus_scl && !prev_sda && bus_sda) begin
            bus_log.push_back(MK_STOP);
            bitn = 0; mode_read = 1'b0; pend_read = 1'b0; slave_low = 1'b0;
        end else if (!prev_scl && bus_scl) begin
            bitn++;
            if (mode_read) begin
                if (bitn == 9) mack = bus_sda;
            end else if (bitn <= 8) begin
                rx = {rx[6:0], bus_sda};
            end
        end else if (prev_scl && !bus_scl) begin
            if (bitn == 8) begin
                if (mode_read) begin
                    slave_low = 1'b0;
                end else begin
                    bus_log.push_back(int'(rx));
                    slave_low = present;
                    if (first_byte && rx[0] && present) pend_read = 1'b1;
                    first_byte = 1'b0;
                end
            end else if (bitn == 9) begin
                bitn = 0;
                if (pend_read || (mode_read && !mack)) begin
                    if (mode_read) mack_log.push_back(int'(mack));
                    pend_read = 1'b0;
                    mode_read = 1'b1;
                    tx = (rd_idx < rd_vals.size()) ? rd_vals[rd_idx] : 8'hFF;
                    rd_idx++;
                    slave_low = !tx[7];
                end else begin
                    if (mode_read) mack_log.push_back(int'(mack));
                    mode_read = 1'b0;
                    slave_low = 1'b0;
                end
            end else if (mode_read && bitn < 8) begin
                slave_low = !tx[7-bitn];
            end
        end
        prev_scl = bus_scl;
        prev_sda = bus_sda;
    end

    always @(negedge clk) begin
        if (wr_req_sel) begin
            wr_cnt++;
            wr_data = (wr_idx < wr_vals.size()) ? wr_vals[wr_idx] : 8'h00;
            wr_idx++;
        end
        if (rd_valid_sel) rd_log.push_back(rd_data_sel);
        if (done_sel) begin
            done_cnt++;
            nack_at_done = nack_sel;
        end
        if (nack_sel && !done_sel) nack_stray++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag);
        check({tag, "_nbytes"}, bus_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < bus_log.size(); i++)
            check($sformatf("%s_b%0d", tag, i), bus_log[i], exp_log[i]);
    endtask

    task automatic clear_logs();
        bus_log.delete(); mack_log.delete(); rd_log.delete();
        rd_idx = 0; wr_idx = 0; wr_cnt = 0; done_cnt = 0; nack_stray = 0; nack_at_done = 1'b0;
    endtask

    task automatic start_op(input logic use_b, input logic [15:0] addr, input logic [7:0] len,
                            input logic typ);
        @(negedge clk);
        slave_addr = 7'h50; op_addr_a = addr; op_addr_b = addr[7:0]; op_len = len; op_type = typ;
        if (use_b) valid_b = 1'b1; else valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0; valid_b = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done_sel && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, (n < 4000), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_scl", scl_a, 1'b1);
        check("rst_sda", sda_a, 1'b1);
        check("rst_ready", ready_a, 1'b1);
        check("rst_wr_req", wr_req_a, 1'b0);
        check("rst_rd_valid", rd_valid_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_nack", nack_a, 1'b0);
        check("rst_rd_data", rd_data_a, 8'h00);

        // 1: page write of three bytes
        clear_logs(); present = 1'b1; wr_vals = '{8'hA5, 8'h5A, 8'hFF};
        start_op(1'b0, 16'h1234, 8'd3, 1'b0);
        check("s1_ready_low", ready_a, 1'b0);
        wait_done("s1");
        exp_log = '{MK_START, 'hA0, 'h12, 'h34, 'hA5, 'h5A, 'hFF, MK_STOP};
        check_log("s1");
        check("s1_wr_req_cnt", wr_cnt, 3);
        check("s1_done_cnt", done_cnt, 1);
        check("s1_nack", nack_at_done, 1'b0);
        check("s1_stray_nack", nack_stray, 0);
        check("s1_ready_back", ready_a, 1'b1);

        // 2: sequential random read of four bytes
        clear_logs(); rd_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        start_op(1'b0, 16'h0010, 8'd4, 1'b1);
        wait_done("s2");
        exp_log = '{MK_START, 'hA0, 'h00, 'h10, MK_START, 'hA1, MK_STOP};
        check_log("s2");
        check("s2_mack_n", mack_log.size(), 4);
        for (int i = 0; i < 4 && i < mack_log.size(); i++)
            check($sformatf("s2_mack%0d", i), mack_log[i], (i == 3) ? 1 : 0);
        check("s2_rd_n", rd_log.size(), 4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++)
            check($sformatf("s2_rd%0d", i), rd_log[i], 8'h11 * (i + 1));
        check("s2_rd_hold", rd_data_a, 8'h44);
        check("s2_done_cnt", done_cnt, 1);
        check("s2_nack", nack_at_done, 1'b0);
        check("s2_wr_req_cnt", wr_cnt, 0);

        // 3: no device present
        clear_logs(); present = 1'b0; wr_vals = '{8'h01, 8'h02};
        start_op(1'b0, 16'h1234, 8'd2, 1'b0);
        wait_done("s3");
        exp_log = '{MK_START, 'hA0, MK_STOP};
        check_log("s3");
        check("s3_wr_req_cnt", wr_cnt, 0);
        check("s3_done_cnt", done_cnt, 1);
        check("s3_nack", nack_at_done, 1'b1);
        check("s3_stray_nack", nack_stray, 0);

        // 4: one address byte variant
        clear_logs(); present = 1'b1; sel_b = 1'b1; wr_vals = '{8'h3C};
        repeat (2) @(negedge clk);
        start_op(1'b1, 16'h007F, 8'd1, 1'b0);
        wait_done("s4");
        exp_log = '{MK_START, 'hA0, 'h7F, 'h3C, MK_STOP};
        check_log("s4");
        check("s4_wr_req_cnt", wr_cnt, 1);
        check("s4_nack", nack_at_done, 1'b0);
        check("s4_ready_b", ready_b, 1'b1);
        sel_b = 1'b0;
        repeat (2) @(negedge clk);

        // 5: zero-length write (ack polling), present then absent
        clear_logs(); present = 1'b1;
        start_op(1'b0, 16'h0000, 8'd0, 1'b0);
        wait_done("s5a");
        exp_log = '{MK_START, 'hA0, 'h00, 'h00, MK_STOP};
        check_log("s5a");
        check("s5a_wr_req_cnt", wr_cnt, 0);
        check("s5a_nack", nack_at_done, 1'b0);
        clear_logs(); present = 1'b0;
        start_op(1'b0, 16'h0000, 8'd0, 1'b0);
        wait_done("s5b");
        exp_log = '{MK_START, 'hA0, MK_STOP};
        check_log("s5b");
        check("s5b_nack", nack_at_done, 1'b1);
        check("s5b_done_cnt", done_cnt, 1);

        // 6: reset in the middle of address byte 0x12, then a clean op
        clear_logs(); present = 1'b1; wr_vals = '{8'hA5, 8'h5A, 8'hFF};
        start_op(1'b0, 16'h1234, 8'd3, 1'b0);
        begin
            int n = 0;
            while (!(bus_log.size() == 2 && bitn >= 3 && bitn < 8) && n < 4000) begin
                @(negedge clk);
                n++;
            end
            check("s6_reach_timeout", (n < 4000), 1);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("s6_rst_scl", scl_a, 1'b1);
        check("s6_rst_sda", sda_a, 1'b1);
        check("s6_rst_ready", ready_a, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        clear_logs(); wr_vals = '{8'h11, 8'h22, 8'h33};
        start_op(1'b0, 16'h1234, 8'd3, 1'b0);
        repeat (100) @(negedge clk);
        slave_addr = 7'h22; op_type = 1'b1; op_len = 8'd5; op_addr_a = 16'hBEEF;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        wait_done("s6");
        exp_log = '{MK_START, 'hA0, 'h12, 'h34, 'h11, 'h22, 'h33, MK_STOP};
        check_log("s6");
        check("s6_wr_req_cnt", wr_cnt, 3);
        check("s6_done_cnt", done_cnt, 1);
        check("s6_nack", nack_at_done, 1'b0);
        repeat (20) @(negedge clk);
        check("s6_still_idle_scl", scl_a, 1'b1);
        check("s6_ready_end", ready_a, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
